rvc_compressor: RTL and testbench
=================================

Name: rvc_compressor

Overview:
Streaming RV32C compressor, the inverse of the instruction decompressor. It accepts 32-bit RV32I instructions on a valid/ready stream and rewrites each compressible instruction as its 16-bit RVC form. It packs the resulting halfword stream little-endian into 32-bit memory words on a valid/ready output. It sits between the program-loader/self-test generator and instruction memory, and produces packed code images for the compressed fetch path.

Parameters:
ENABLE_C, 1, 1 = apply compression rules; 0 = every 32-bit input passes through uncompressed (packing logic still active)
CNT_W, 16, width of the compressed-instruction counter

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
in_instr_i  input  32  instruction to compress
in_valid_i  input  1  in_instr_i valid
in_ready_o  output  1  compressor can accept
flush_i  input  1  request to emit any pending halfword padded with C.NOP
out_word_o  output  32  packed memory word; bits [15:0] = lower address
out_valid_o  output  1  out_word_o valid
out_ready_i  input  1  consumer accepts out_word_o
idle_o  output  1  no pending halfword and output register empty
comp_count_o  output  CNT_W  number of instructions emitted in 16-bit form

Behaviour:
- Reset (async, immediate): out_valid_o=0, out_word_o=0, pending flag=0, pending halfword=0, comp_count_o=0, idle_o=1, in_ready_o=1.
- in_ready_o = ~out_valid_o | out_ready_i (combinational). Transfer occurs when in_valid_i & in_ready_o. Output transfer occurs when out_valid_o & out_ready_i. Both may occur in the same cycle.
- Input with in_instr_i[1:0]!=2'b11 is already compressed: treat in_instr_i[15:0] as one halfword unchanged. It is not counted.
- Compression rules, checked in this order when ENABLE_C=1 (imm = I/S immediate, sign-extended):
  - ADDI x0,x0,0 -> C.NOP 0x0001.
  - ADDI rd!=0, rs1=x0, imm in [-32,31] -> C.LI.
  - ADDI rd=rs1!=0, imm!=0, imm in [-32,31] -> C.ADDI.
  - SLLI rd=rs1!=0, shamt!=0 -> C.SLLI.
  - ADD rd!=0, rs1=x0, rs2!=0 -> C.MV.
  - ADD rd=rs1!=0, rs2!=0 -> C.ADD.
  - LW rd!=0, rs1=x2, imm%4==0, imm in [0,252] -> C.LWSP.
  - SW rs1=x2, imm%4==0, imm in [0,252] -> C.SWSP.
  - LW/SW with rd/rs2 and rs1 in x8..x15, imm%4==0, imm in [0,124] -> C.LW/C.SW.
  - All other instructions, including every branch, jump and AUIPC, stay 32-bit. PC-relative offset relocation is the producer's responsibility.
- Packing, evaluated on an input transfer. P = pending flag, H = pending halfword, c = 16-bit result.
  - P=0, 16-bit: H<=c, P<=1, no output.
  - P=0, 32-bit: output word = instr.
  - P=1, 16-bit: output {c,H}, P<=0.
  - P=1, 32-bit: output {instr[15:0],H}, H<=instr[31:16], P stays 1.
- Output word registered: produced word appears on out_word_o with out_valid_o=1 the cycle after the input transfer. Latency is 1 cycle whenever a word is produced. out_word_o is held stable while out_valid_o=1 & ~out_ready_i.
- Flush: acts in a cycle with flush_i=1, in_valid_i=0 and in_ready_o=1.
  - P=1: output {16'h0001,H}, P<=0.
  - P=0: no effect.
  - If in_valid_i=1, the instruction has priority and flush_i must be held by the requester.
- comp_count_o increments by 1 per transferred instruction emitted in RVC form (C.NOP included). It wraps at 2^CNT_W.
- idle_o = ~P & ~out_valid_o.
- Reset mid-stream discards the pending halfword and any unaccepted output word.

Test Plan:
- 0x00500513 (addi a0,x0,5) then 0x00B00533 (add a0,x0,a1) -> one word 0x852E4515, comp_count_o=2, idle_o=1 after acceptance.
- 0x123452B7 (lui) with P=0 -> 0x123452B7 one cycle later, comp_count_o unchanged.
- 0x00500513 then 0x123452B7 -> word 0x52B74515, P=1. Then flush_i -> 0x00011234, idle_o=1.
- 0x00442503 (lw a0,4(s0)) then 0x00000013 -> 0x00014048. Also 0x08042503 (offset 128) stays 32-bit, not counted.
- Hold out_ready_i=0 with a word pending and in_valid_i=1 -> in_ready_o=0, out_word_o stable. Release -> stream resumes with no loss or duplication.
- ENABLE_C=0 with 0x00500513, 0x00B00533 -> two words identical to the inputs. Also assert rst_i mid-stream with P=1 -> outputs return to reset values immediately.

Source files
------------

// File: rtl/rvc_compressor.sv
// Streaming RV32C compressor: rewrites compressible RV32I instructions as RVC
// halfwords and packs the halfword stream little-endian into 32-bit words.
module rvc_compressor #(
  parameter bit          ENABLE_C = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      in_instr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  output logic [31:0]      out_word_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             idle_o,
  output logic [CNT_W-1:0] comp_count_o
);

  logic [31:0]      r_out_word;
  logic             r_out_valid;
  logic             r_pend;
  logic [15:0]      r_half;
  logic [CNT_W-1:0] r_cnt;

  logic [6:0]  w_opc;
  logic [6:0]  w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [11:0] w_imm_i;
  logic [11:0] w_imm_s;
  logic        w_imm_small;
  logic        w_is_addi;
  logic        w_is_slli;
  logic        w_is_add;
  logic        w_is_lw;
  logic        w_is_sw;
  logic        w_rd_p;
  logic        w_rs1_p;
  logic        w_rs2_p;
  logic        w_cmp;
  logic [15:0] w_chalf;
  logic        w_pre;
  logic        w_is16;
  logic [15:0] w_half;
  logic        w_in_fire;
  logic        w_out_fire;
  logic        w_flush_fire;

  assign w_opc   = in_instr_i[6:0];
  assign w_rd    = in_instr_i[11:7];
  assign w_f3    = in_instr_i[14:12];
  assign w_rs1   = in_instr_i[19:15];
  assign w_rs2   = in_instr_i[24:20];
  assign w_f7    = in_instr_i[31:25];
  assign w_imm_i = in_instr_i[31:20];
  assign w_imm_s = {in_instr_i[31:25], in_instr_i[11:7]};

  assign w_imm_small = (w_imm_i[11:5] == '0) | (w_imm_i[11:5] == '1);
  assign w_is_addi   = (w_opc == 7'b0010011) & (w_f3 == 3'b000);
  assign w_is_slli   = (w_opc == 7'b0010011) & (w_f3 == 3'b001) & (w_f7 == '0);
  assign w_is_add    = (w_opc == 7'b0110011) & (w_f3 == 3'b000) & (w_f7 == '0);
  assign w_is_lw     = (w_opc == 7'b0000011) & (w_f3 == 3'b010);
  assign w_is_sw     = (w_opc == 7'b0100011) & (w_f3 == 3'b010);
  assign w_rd_p      = (w_rd[4:3]  == 2'b01);
  assign w_rs1_p     = (w_rs1[4:3] == 2'b01);
  assign w_rs2_p     = (w_rs2[4:3] == 2'b01);

  // Rule order matters: the first matching form wins.
  always_comb begin
    w_cmp   = 1'b0;
    w_chalf = '0;
    if (ENABLE_C && (in_instr_i[1:0] == 2'b11)) begin
      w_cmp = 1'b1;
      if (w_is_addi && w_rd == '0 && w_rs1 == '0 && w_imm_i == '0)
        w_chalf = 16'h0001;
      else if (w_is_addi && w_rd != '0 && w_rs1 == '0 && w_imm_small)
        w_chalf = {3'b010, w_imm_i[5], w_rd, w_imm_i[4:0], 2'b01};
      else if (w_is_addi && w_rd != '0 && w_rd == w_rs1 && w_imm_i != '0 && w_imm_small)
        w_chalf = {3'b000, w_imm_i[5], w_rd, w_imm_i[4:0], 2'b01};
      else if (w_is_slli && w_rd != '0 && w_rd == w_rs1 && w_rs2 != '0)
        w_chalf = {3'b000, 1'b0, w_rd, w_rs2, 2'b10};
      else if (w_is_add && w_rd != '0 && w_rs1 == '0 && w_rs2 != '0)
        w_chalf = {4'b1000, w_rd, w_rs2, 2'b10};
      else if (w_is_add && w_rd != '0 && w_rd == w_rs1 && w_rs2 != '0)
        w_chalf = {4'b1001, w_rd, w_rs2, 2'b10};
      else if (w_is_lw && w_rd != '0 && w_rs1 == 5'd2 && w_imm_i[11:8] == '0 && w_imm_i[1:0] == '0)
        w_chalf = {3'b010, w_imm_i[5], w_rd, w_imm_i[4:2], w_imm_i[7:6], 2'b10};
      else if (w_is_sw && w_rs1 == 5'd2 && w_imm_s[11:8] == '0 && w_imm_s[1:0] == '0)
        w_chalf = {3'b110, w_imm_s[5:2], w_imm_s[7:6], w_rs2, 2'b10};
      else if (w_is_lw && w_rd_p && w_rs1_p && w_imm_i[11:7] == '0 && w_imm_i[1:0] == '0)
        w_chalf = {3'b010, w_imm_i[5:3], w_rs1[2:0], w_imm_i[2], w_imm_i[6], w_rd[2:0], 2'b00};
      else if (w_is_sw && w_rs2_p && w_rs1_p && w_imm_s[11:7] == '0 && w_imm_s[1:0] == '0)
        w_chalf = {3'b110, w_imm_s[5:3], w_rs1[2:0], w_imm_s[2], w_imm_s[6], w_rs2[2:0], 2'b00};
      else
        w_cmp = 1'b0;
    end
  end

  assign w_pre  = (in_instr_i[1:0] != 2'b11);
  assign w_is16 = w_pre | w_cmp;
  assign w_half = w_pre ? in_instr_i[15:0] : w_chalf;

  assign in_ready_o   = ~r_out_valid | out_ready_i;
  assign w_in_fire    = in_valid_i & in_ready_o;
  assign w_out_fire   = r_out_valid & out_ready_i;
  assign w_flush_fire = flush_i & ~in_valid_i & in_ready_o & r_pend;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_word  <= '0;
      r_out_valid <= 1'b0;
      r_pend      <= 1'b0;
      r_half      <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_out_fire) r_out_valid <= 1'b0;
      if (w_in_fire) begin
        if (w_cmp) r_cnt <= r_cnt + CNT_W'(1);
        if (!r_pend) begin
          if (w_is16) begin
            r_half <= w_half;
            r_pend <= 1'b1;
          end else begin
            r_out_word  <= in_instr_i;
            r_out_valid <= 1'b1;
          end
        end else if (w_is16) begin
          r_out_word  <= {w_half, r_half};
          r_out_valid <= 1'b1;
          r_pend      <= 1'b0;
        end else begin
          // Upper half of a 32-bit instruction straddles into the next word.
          r_out_word  <= {in_instr_i[15:0], r_half};
          r_out_valid <= 1'b1;
          r_half      <= in_instr_i[31:16];
        end
      end else if (w_flush_fire) begin
        r_out_word  <= {16'h0001, r_half};
        r_out_valid <= 1'b1;
        r_pend      <= 1'b0;
      end
    end
  end

  assign out_word_o   = r_out_word;
  assign out_valid_o  = r_out_valid;
  assign idle_o       = ~r_pend & ~r_out_valid;
  assign comp_count_o = r_cnt;

endmodule

// File: tb/tb_rvc_compressor.sv
// Bench for rvc_compressor: vector table, hand sequences and randomized stream
// checked against a halfword-queue reference model.
module tb_rvc_compressor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] in_instr_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        flush_i;
  logic [31:0] out_word_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        idle_o;
  logic [15:0] comp_count_o;

  logic [31:0] in_instr0;
  logic        in_valid0;
  logic        in_ready0;
  logic        flush0;
  logic [31:0] out_word0;
  logic        out_valid0;
  logic        out_ready0;
  logic        idle0;
  logic [15:0] comp_count0;

  always #5 clk_i = ~clk_i;

  rvc_compressor #(.ENABLE_C(1'b1), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_instr_i(in_instr_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .flush_i(flush_i), .out_word_o(out_word_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .idle_o(idle_o),
    .comp_count_o(comp_count_o)
  );

  rvc_compressor #(.ENABLE_C(1'b0), .CNT_W(16)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .in_instr_i(in_instr0), .in_valid_i(in_valid0),
    .in_ready_o(in_ready0), .flush_i(flush0), .out_word_o(out_word0),
    .out_valid_o(out_valid0), .out_ready_i(out_ready0), .idle_o(idle0),
    .comp_count_o(comp_count0)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] hq[$];
  logic [31:0] wq[$];
  int          mcount;
  logic [31:0] last_word;

  typedef struct {
    logic [31:0] instr;
    logic        is16;
    logic [15:0] half;
    logic        counted;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference compression from the instruction-set rules, using signed arithmetic.
  function automatic bit ref_comp(input logic [31:0] i, output logic [15:0] h);
    int opc, f3, f7, rd, rs1, rs2, imm_i, imm_s;
    logic [7:0] u;
    logic [7:0] s;
    opc   = int'(i[6:0]);
    f3    = int'(i[14:12]);
    f7    = int'(i[31:25]);
    rd    = int'(i[11:7]);
    rs1   = int'(i[19:15]);
    rs2   = int'(i[24:20]);
    imm_i = int'($signed(i[31:20]));
    imm_s = int'($signed({i[31:25], i[11:7]}));
    u     = 8'(imm_i);
    s     = 8'(imm_s);
    h     = 16'h0000;
    if (opc == 'h13 && f3 == 0) begin
      if (rd == 0 && rs1 == 0 && imm_i == 0) begin h = 16'h0001; return 1'b1; end
      if (rd != 0 && rs1 == 0 && imm_i >= -32 && imm_i <= 31) begin
        h = {3'b010, u[5], 5'(rd), u[4:0], 2'b01}; return 1'b1;
      end
      if (rd != 0 && rd == rs1 && imm_i != 0 && imm_i >= -32 && imm_i <= 31) begin
        h = {3'b000, u[5], 5'(rd), u[4:0], 2'b01}; return 1'b1;
      end
    end
    if (opc == 'h13 && f3 == 1 && f7 == 0 && rd != 0 && rd == rs1 && rs2 != 0) begin
      h = {4'b0000, 5'(rd), 5'(rs2), 2'b10}; return 1'b1;
    end
    if (opc == 'h33 && f3 == 0 && f7 == 0) begin
      if (rd != 0 && rs1 == 0 && rs2 != 0) begin h = {4'b1000, 5'(rd), 5'(rs2), 2'b10}; return 1'b1; end
      if (rd != 0 && rd == rs1 && rs2 != 0) begin h = {4'b1001, 5'(rd), 5'(rs2), 2'b10}; return 1'b1; end
    end
    if (opc == 'h03 && f3 == 2 && imm_i % 4 == 0 && imm_i >= 0) begin
      if (rd != 0 && rs1 == 2 && imm_i <= 252) begin
        h = {3'b010, u[5], 5'(rd), u[4:2], u[7:6], 2'b10}; return 1'b1;
      end
      if (rd >= 8 && rd <= 15 && rs1 >= 8 && rs1 <= 15 && imm_i <= 124) begin
        h = {3'b010, u[5:3], 3'(rs1 - 8), u[2], u[6], 3'(rd - 8), 2'b00}; return 1'b1;
      end
    end
    if (opc == 'h23 && f3 == 2 && imm_s % 4 == 0 && imm_s >= 0) begin
      if (rs1 == 2 && imm_s <= 252) begin
        h = {3'b110, s[5:2], s[7:6], 5'(rs2), 2'b10}; return 1'b1;
      end
      if (rs2 >= 8 && rs2 <= 15 && rs1 >= 8 && rs1 <= 15 && imm_s <= 124) begin
        h = {3'b110, s[5:3], 3'(rs1 - 8), s[2], s[6], 3'(rs2 - 8), 2'b00}; return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_pack();
    while (hq.size() >= 2) begin
      wq.push_back({hq[1], hq[0]});
      void'(hq.pop_front());
      void'(hq.pop_front());
    end
  endtask

  task automatic model_push(input logic [31:0] ins);
    logic [15:0] h;
    if (ins[1:0] != 2'b11) hq.push_back(ins[15:0]);
    else if (ref_comp(ins, h)) begin
      hq.push_back(h);
      mcount++;
    end else begin
      hq.push_back(ins[15:0]);
      hq.push_back(ins[31:16]);
    end
    model_pack();
  endtask

  task automatic model_reset();
    hq.delete();
    wq.delete();
    mcount = 0;
  endtask

  // One clock: inputs driven at posedge+1, DUT observed at the negedge.
  task automatic step(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
    in_valid_i  = v;
    in_instr_i  = ins;
    out_ready_i = rdy;
    flush_i     = fl;
    @(negedge clk_i);
    chk("out_valid", {31'b0, out_valid_o}, {31'b0, wq.size() != 0});
    chk("idle", {31'b0, idle_o}, {31'b0, hq.size() == 0 && wq.size() == 0});
    if (out_valid_o && rdy) begin
      last_word = out_word_o;
      if (wq.size() == 0) chk("unexpected_word", out_word_o, 32'hxxxxxxxx);
      else chk("stream_word", out_word_o, wq.pop_front());
    end
    if (v && in_ready_o) model_push(ins);
    else if (fl && !v && in_ready_o && hq.size() == 1) begin
      hq.push_back(16'h0001);
      model_pack();
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 10 && !(hq.size() == 0 && wq.size() == 0); n++) step(1'b0, '0, 1'b1, 1'b1);
    chk("drain_idle", {31'b0, idle_o}, 32'd1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [31:0] r;
    logic [6:0]  f7;
    rd  = 5'($urandom);
    rs2 = 5'($urandom);
    rs1 = 5'($urandom);
    f7  = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
    r   = $urandom;
    case ($urandom_range(0, 8))
      0: begin
        if ($urandom_range(0, 1) == 1) rs1 = rd; else if ($urandom_range(0, 1) == 1) rs1 = '0;
        imm = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 80)) - 12'd40;
        return {imm, rs1, 3'b000, rd, 7'b0010011};
      end
      1: return {f7, rs2, rd, 3'b001, rd, 7'b0010011};
      2: begin
        if ($urandom_range(0, 1) == 1) rs1 = rd; else if ($urandom_range(0, 1) == 1) rs1 = '0;
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
      end
      3, 4: begin
        case ($urandom_range(0, 2))
          0: rs1 = 5'd2;
          1: rs1 = 5'd8 + 5'($urandom_range(0, 7));
          default: ;
        endcase
        if ($urandom_range(0, 1) == 1) rd = 5'd8 + 5'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) rs2 = 5'd8 + 5'($urandom_range(0, 7));
        case ($urandom_range(0, 2))
          0: imm = 12'($urandom_range(0, 70) * 4);
          1: imm = 12'($urandom_range(0, 300));
          default: imm = 12'($urandom);
        endcase
        if (($urandom & 1) == 1) return {imm, rs1, 3'b010, rd, 7'b0000011};
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      end
      5: begin r[1:0] = 2'b11; return r; end
      6: begin r[1:0] = 2'($urandom_range(0, 2)); return r; end
      7: return 32'h00000013;
      default: begin
        case ($urandom_range(0, 3))
          0: r[6:0] = 7'b0110111;
          1: r[6:0] = 7'b0010111;
          2: r[6:0] = 7'b1101111;
          default: r[6:0] = 7'b1100011;
        endcase
        return r;
      end
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    logic [15:0] c0;

    vt.push_back('{32'h00500513, 1'b1, 16'h4515, 1'b1});
    vt.push_back('{32'h00B00533, 1'b1, 16'h852E, 1'b1});
    vt.push_back('{32'h00000013, 1'b1, 16'h0001, 1'b1});
    vt.push_back('{32'h00442503, 1'b1, 16'h4048, 1'b1});
    vt.push_back('{32'h08042503, 1'b0, 16'h0000, 1'b0});
    vt.push_back('{32'h123452B7, 1'b0, 16'h0000, 1'b0});
    vt.push_back('{32'hFFF50513, 1'b1, 16'h157D, 1'b1});
    vt.push_back('{32'h00050513, 1'b0, 16'h0000, 1'b0});
    vt.push_back('{32'hFE000513, 1'b1, 16'h5501, 1'b1});
    vt.push_back('{32'h02000513, 1'b0, 16'h0000, 1'b0});
    vt.push_back('{32'h00351513, 1'b1, 16'h050E, 1'b1});
    vt.push_back('{32'h00B50533, 1'b1, 16'h952E, 1'b1});
    vt.push_back('{32'h0FC12503, 1'b1, 16'h557E, 1'b1});
    vt.push_back('{32'h10012503, 1'b0, 16'h0000, 1'b0});
    vt.push_back('{32'h00B12423, 1'b1, 16'hC42E, 1'b1});
    vt.push_back('{32'h06942E23, 1'b1, 16'hDC64, 1'b1});
    vt.push_back('{32'h00B50463, 1'b0, 16'h0000, 1'b0});
    vt.push_back('{32'h00500013, 1'b0, 16'h0000, 1'b0});
    vt.push_back('{32'h00242503, 1'b0, 16'h0000, 1'b0});
    vt.push_back('{32'h0000852E, 1'b1, 16'h852E, 1'b0});

    rst_i = 1'b1;
    in_valid_i = 1'b0; in_instr_i = '0; out_ready_i = 1'b0; flush_i = 1'b0;
    in_valid0 = 1'b0; in_instr0 = '0; out_ready0 = 1'b1; flush0 = 1'b0;
    last_word = '0;
    model_reset();
    #12;
    chk("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
    chk("rst_out_word", out_word_o, 32'd0);
    chk("rst_idle", {31'b0, idle_o}, 32'd1);
    chk("rst_in_ready", {31'b0, in_ready_o}, 32'd1);
    chk("rst_count", {16'b0, comp_count_o}, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // li + mv pack into one word
    step(1'b1, 32'h00500513, 1'b1, 1'b0);
    step(1'b1, 32'h00B00533, 1'b1, 1'b0);
    chk("pair_word", out_word_o, 32'h852E4515);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("pair_idle", {31'b0, idle_o}, 32'd1);
    chk("pair_count", {16'b0, comp_count_o}, 32'd2);

    // 32-bit pass-through latency
    step(1'b1, 32'h123452B7, 1'b1, 1'b0);
    chk("lui_valid", {31'b0, out_valid_o}, 32'd1);
    chk("lui_word", out_word_o, 32'h123452B7);
    chk("lui_count", {16'b0, comp_count_o}, 32'd2);
    step(1'b0, '0, 1'b1, 1'b0);

    // straddling 32-bit instruction then flush
    step(1'b1, 32'h00500513, 1'b1, 1'b0);
    step(1'b1, 32'h123452B7, 1'b1, 1'b0);
    chk("straddle_word", out_word_o, 32'h52B74515);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("flush_word", out_word_o, 32'h00011234);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("flush_idle", {31'b0, idle_o}, 32'd1);

    // c.lw + c.nop, then out-of-range offset
    c0 = comp_count_o;
    step(1'b1, 32'h00442503, 1'b1, 1'b0);
    step(1'b1, 32'h00000013, 1'b1, 1'b0);
    chk("clw_word", out_word_o, 32'h00014048);
    step(1'b1, 32'h08042503, 1'b1, 1'b0);
    chk("lw128_word", out_word_o, 32'h08042503);
    chk("lw128_count", {16'b0, comp_count_o - c0}, 32'd2);
    step(1'b0, '0, 1'b1, 1'b0);

    // backpressure: stall with a held word, then resume
    step(1'b1, 32'h123452B7, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'h00500513, 1'b0, 1'b0);
      chk("stall_ready", {31'b0, in_ready_o}, 32'd0);
      chk("stall_word", out_word_o, 32'h123452B7);
    end
    step(1'b1, 32'h00500513, 1'b1, 1'b0);
    chk("resume_accept", last_word, 32'h123452B7);
    step(1'b1, 32'h00B00533, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("resume_word", last_word, 32'h852E4515);
    drain();

    foreach (vt[k]) begin
      c0 = comp_count_o;
      step(1'b1, vt[k].instr, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0);
      chk($sformatf("vec%0d_word", k), last_word, vt[k].is16 ? {16'h0001, vt[k].half} : vt[k].instr);
      chk($sformatf("vec%0d_count", k), {16'b0, comp_count_o - c0}, {31'b0, vt[k].counted});
    end

    for (int n = 0; n < 3000; n++)
      step(($urandom_range(0, 3) != 0), rand_instr(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
    drain();
    chk("rand_count", {16'b0, comp_count_o}, {16'b0, 16'(mcount)});

    // ENABLE_C=0: compressible inputs pass through as full words
    in_valid0 = 1'b1; in_instr0 = 32'h00500513;
    @(posedge clk_i); #1;
    chk("nc_valid", {31'b0, out_valid0}, 32'd1);
    chk("nc_word0", out_word0, 32'h00500513);
    in_instr0 = 32'h00B00533;
    @(posedge clk_i); #1;
    chk("nc_word1", out_word0, 32'h00B00533);
    in_valid0 = 1'b0;
    chk("nc_count", {16'b0, comp_count0}, 32'd0);
    @(posedge clk_i); #1;

    // asynchronous reset with a pending halfword and a held word
    step(1'b1, 32'h00500513, 1'b0, 1'b0);
    step(1'b1, 32'h123452B7, 1'b0, 1'b0);
    in_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid_o}, 32'd0);
    chk("mid_rst_word", out_word_o, 32'd0);
    chk("mid_rst_idle", {31'b0, idle_o}, 32'd1);
    chk("mid_rst_count", {16'b0, comp_count_o}, 32'd0);
    chk("mid_rst_ready", {31'b0, in_ready_o}, 32'd1);
    model_reset();
    #1 rst_i = 1'b0;
    @(posedge clk_i); #1;
    step(1'b1, 32'h00500513, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("post_rst_word", last_word, 32'h00014515);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
